// File: rtl/bnn_acc_l1_cfu.sv
// bnn_acc_l1_cfu: XNOR/popcount dot product of two operands, optionally folded into one of CFU_N_STATES signed accumulators.
// Latency: CFU_LAT enabled cycles from request to response. The popcount is split over stages 1..CFU_LAT-1, and the last stage does the accumulator RMW.
// Backpressure: none; one request per enabled cycle, and clk_en low freezes every register. Optional feature macro: BNN_ACC_SATURATE_EN (MAC saturates).
module bnn_acc_l1_cfu #(
    parameter int CFU_LAT       = 2,
    parameter int CFU_DATA_W    = 32,
    parameter int CFU_N_STATES  = 4,
    parameter int CFU_FUNC_ID_W = 3,
    parameter int CFU_STATE_W   = (CFU_N_STATES > 1) ? $clog2(CFU_N_STATES) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clk_en,
    input  logic                     req_valid,
    input  logic [CFU_STATE_W-1:0]   req_state,
    input  logic [CFU_FUNC_ID_W-1:0] req_func,
    input  logic [CFU_DATA_W-1:0]    req_data0,
    input  logic [CFU_DATA_W-1:0]    req_data1,
    output logic                     resp_valid,
    output logic [2:0]               resp_status,
    output logic [CFU_DATA_W-1:0]    resp_data
);

    localparam int PC_W    = $clog2(CFU_DATA_W + 1);
    // Number of popcount chunks; one chunk per pre-final stage (a single dummy slot when CFU_LAT == 1).
    localparam int N_CHUNK = (CFU_LAT > 1) ? CFU_LAT - 1 : 1;

    localparam logic [CFU_FUNC_ID_W-1:0] F_DOT   = CFU_FUNC_ID_W'(0);
    localparam logic [CFU_FUNC_ID_W-1:0] F_MAC   = CFU_FUNC_ID_W'(1);
    localparam logic [CFU_FUNC_ID_W-1:0] F_READ  = CFU_FUNC_ID_W'(2);
    localparam logic [CFU_FUNC_ID_W-1:0] F_CLEAR = CFU_FUNC_ID_W'(3);
    localparam logic [CFU_FUNC_ID_W-1:0] F_LOAD  = CFU_FUNC_ID_W'(4);
    localparam logic [2:0] ST_OK  = 3'd0;
    localparam logic [2:0] ST_ERR = 3'd1;
`ifdef BNN_ACC_SATURATE_EN
    localparam logic [2:0] ST_SAT = 3'd2;
`endif

    generate
        if (CFU_LAT < 1 || CFU_LAT > 8) begin : g_bad_lat
            $error("bnn_acc_l1_cfu: CFU_LAT must be in 1..8");
        end
        if (CFU_DATA_W != 32 && CFU_DATA_W != 64) begin : g_bad_w
            $error("bnn_acc_l1_cfu: CFU_DATA_W must be 32 or 64");
        end
        if (CFU_N_STATES < 1 || (CFU_N_STATES & (CFU_N_STATES - 1)) != 0) begin : g_bad_n
            $error("bnn_acc_l1_cfu: CFU_N_STATES must be a power of two");
        end
        if (CFU_FUNC_ID_W < 3) begin : g_bad_f
            $error("bnn_acc_l1_cfu: CFU_FUNC_ID_W must be at least 3");
        end
    endgenerate

    // Count the set bits of x in the bit range [lo, hi).
    function automatic logic [PC_W-1:0] f_chunk_pc(input logic [CFU_DATA_W-1:0] x, input int lo, input int hi);
        logic [PC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < CFU_DATA_W; i++) begin
            if (i >= lo && i < hi) cnt = cnt + PC_W'(x[i]);
        end
        return cnt;
    endfunction

    // Stage view: index 0 is the incoming request and index s>0 is pipeline register s.
    logic                     w_vld   [0:CFU_LAT-1];
    logic [CFU_STATE_W-1:0]   w_state [0:CFU_LAT-1];
    logic [CFU_FUNC_ID_W-1:0] w_func  [0:CFU_LAT-1];
    logic [CFU_DATA_W-1:0]    w_a     [0:CFU_LAT-1];
    logic [CFU_DATA_W-1:0]    w_x     [0:CFU_LAT-1];
    logic [PC_W-1:0]          w_pc    [0:CFU_LAT-1];

    logic                     r_vld   [1:N_CHUNK];
    logic [CFU_STATE_W-1:0]   r_state [1:N_CHUNK];
    logic [CFU_FUNC_ID_W-1:0] r_func  [1:N_CHUNK];
    logic [CFU_DATA_W-1:0]    r_a     [1:N_CHUNK];
    logic [CFU_DATA_W-1:0]    r_x     [1:N_CHUNK];
    logic [PC_W-1:0]          r_pc    [1:N_CHUNK];

    logic [CFU_DATA_W-1:0]    r_acc   [0:CFU_N_STATES-1];
    logic                     r_resp_vld;
    logic [2:0]               r_resp_status;
    logic [CFU_DATA_W-1:0]    r_resp_data;

    // Map the request and each pipeline register into the uniform stage view.
    always_comb begin
        w_vld[0]   = req_valid;
        w_state[0] = req_state;
        w_func[0]  = req_func;
        w_a[0]     = req_data0;
        w_x[0]     = ~(req_data0 ^ req_data1);
        w_pc[0]    = '0;
        for (int s = 1; s < CFU_LAT; s++) begin
            w_vld[s]   = r_vld[s];
            w_state[s] = r_state[s];
            w_func[s]  = r_func[s];
            w_a[s]     = r_a[s];
            w_x[s]     = r_x[s];
            w_pc[s]    = r_pc[s];
        end
    end

    // Popcount stages. Each stage adds one chunk of the XNOR word, and payload loads only for valid entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 1; s <= N_CHUNK; s++) begin
                r_vld[s]   <= 1'b0;
                r_state[s] <= '0;
                r_func[s]  <= '0;
                r_a[s]     <= '0;
                r_x[s]     <= '0;
                r_pc[s]    <= '0;
            end
        end else if (clk_en) begin
            for (int s = 1; s < CFU_LAT; s++) begin
                r_vld[s] <= w_vld[s-1];
                if (w_vld[s-1]) begin
                    r_state[s] <= w_state[s-1];
                    r_func[s]  <= w_func[s-1];
                    r_a[s]     <= w_a[s-1];
                    r_x[s]     <= w_x[s-1];
                    r_pc[s]    <= w_pc[s-1] + f_chunk_pc(w_x[s-1], ((s - 1) * CFU_DATA_W) / N_CHUNK,
                                                         (s * CFU_DATA_W) / N_CHUNK);
                end
            end
        end
    end

    // Final stage. With CFU_LAT == 1 the whole popcount is done here; otherwise it is already complete.
    logic [PC_W-1:0]        w_cnt;
    logic [CFU_DATA_W-1:0]  w_dot;
    logic [CFU_STATE_W-1:0] w_idx;
    logic [CFU_DATA_W-1:0]  w_old;
    assign w_cnt = w_pc[CFU_LAT-1] + f_chunk_pc(w_x[CFU_LAT-1], 0, (CFU_LAT == 1) ? CFU_DATA_W : 0);
    assign w_dot = (CFU_DATA_W'(w_cnt) << 1) - CFU_DATA_W'(CFU_DATA_W);
    assign w_idx = (CFU_N_STATES == 1) ? '0 : w_state[CFU_LAT-1];
    assign w_old = r_acc[w_idx];

`ifdef BNN_ACC_SATURATE_EN
    // One extra bit detects signed overflow of the MAC.
    logic [CFU_DATA_W:0] w_sum;
    logic                w_ovf;
    assign w_sum = {w_old[CFU_DATA_W-1], w_old} + {w_dot[CFU_DATA_W-1], w_dot};
    assign w_ovf = w_sum[CFU_DATA_W] ^ w_sum[CFU_DATA_W-1];
`else
    logic [CFU_DATA_W-1:0] w_sum;
    assign w_sum = w_old + w_dot;
`endif

    logic                  w_acc_we;
    logic [CFU_DATA_W-1:0] w_acc_wd;
    logic [CFU_DATA_W-1:0] w_res_data;
    logic [2:0]            w_res_status;

    // Function decode: accumulator write plus the response payload.
    always_comb begin
        w_acc_we     = 1'b0;
        w_acc_wd     = w_old;
        w_res_data   = '0;
        w_res_status = ST_OK;
        case (w_func[CFU_LAT-1])
            F_DOT: w_res_data = w_dot;
            F_MAC: begin
                w_acc_we = 1'b1;
                w_acc_wd = w_sum[CFU_DATA_W-1:0];
`ifdef BNN_ACC_SATURATE_EN
                if (w_ovf) begin
                    w_acc_wd     = w_sum[CFU_DATA_W] ? {1'b1, {(CFU_DATA_W-1){1'b0}}}
                                                     : {1'b0, {(CFU_DATA_W-1){1'b1}}};
                    w_res_status = ST_SAT;
                end
`endif
                w_res_data = w_acc_wd;
            end
            F_READ:  w_res_data = w_old;
            F_CLEAR: begin
                w_acc_we   = 1'b1;
                w_acc_wd   = '0;
                w_res_data = w_old;
            end
            F_LOAD: begin
                w_acc_we   = 1'b1;
                w_acc_wd   = w_a[CFU_LAT-1];
                w_res_data = w_a[CFU_LAT-1];
            end
            default: w_res_status = ST_ERR;
        endcase
    end

    // Accumulator commit. This happens on the same edge that registers the response, so there is no forwarding path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CFU_N_STATES; i++) r_acc[i] <= '0;
        end else if (clk_en && w_vld[CFU_LAT-1] && w_acc_we) begin
            r_acc[w_idx] <= w_acc_wd;
        end
    end

    // Response register. The payload only changes for valid entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_vld    <= 1'b0;
            r_resp_status <= 3'd0;
            r_resp_data   <= '0;
        end else if (clk_en) begin
            r_resp_vld <= w_vld[CFU_LAT-1];
            if (w_vld[CFU_LAT-1]) begin
                r_resp_status <= w_res_status;
                r_resp_data   <= w_res_data;
            end
        end
    end

    assign resp_valid  = r_resp_vld;
    assign resp_status = r_resp_status;
    assign resp_data   = r_resp_data;

endmodule

// File: tb/tb_bnn_acc_l1_cfu.sv
// tb_bnn_acc_l1_cfu: directed test-plan scenarios plus randomized traffic against a reference model.
// Latency: responses are checked exactly CFU_LAT enabled cycles after issue.
// Backpressure: none in the DUT; the bench exercises clk_en stalls and a mid-stream reset.
module tb_bnn_acc_l1_cfu;
    localparam int LAT = 2, W = 32, NS = 4, FW = 3, SW = 2, MAXS = 320;
    localparam int F_DOT = 0, F_MAC = 1, F_READ = 2, F_CLEAR = 3, F_LOAD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clk_en = 1'b0;
    logic          req_valid = 1'b0;
    logic [SW-1:0] req_state = '0;
    logic [FW-1:0] req_func = '0;
    logic [W-1:0]  req_data0 = '0;
    logic [W-1:0]  req_data1 = '0;
    logic          resp_valid;
    logic [2:0]    resp_status;
    logic [W-1:0]  resp_data;

    bnn_acc_l1_cfu #(.CFU_LAT(LAT), .CFU_DATA_W(W), .CFU_N_STATES(NS), .CFU_FUNC_ID_W(FW)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .req_valid(req_valid), .req_state(req_state),
        .req_func(req_func), .req_data0(req_data0), .req_data1(req_data1),
        .resp_valid(resp_valid), .resp_status(resp_status), .resp_data(resp_data));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Slot tables: one request (or bubble) per enabled cycle, and the response observed for each slot.
    logic          sv [MAXS];
    logic [SW-1:0] sst[MAXS];
    logic [FW-1:0] sf [MAXS];
    logic [W-1:0]  sa [MAXS];
    logic [W-1:0]  sb [MAXS];
    logic          ov [MAXS];
    logic [W-1:0]  od [MAXS];
    logic [2:0]    os [MAXS];

    // Reference accumulators.
    logic [W-1:0]  m_acc [NS];

    task automatic set_slot(input int i, input bit v, input int st, input int f, input logic [W-1:0] a, input logic [W-1:0] b);
        sv[i] = v; sst[i] = SW'(st); sf[i] = FW'(f); sa[i] = a; sb[i] = b;
    endtask

    // Drive n slots back to back, and record the outputs seen LAT-1 edges after each slot's sampling edge.
    task automatic run_slots(input int n);
        for (int t = 0; t < n + LAT - 1; t++) begin
            @(negedge clk);
            if (t < n) begin
                req_valid = sv[t]; req_state = sst[t]; req_func = sf[t]; req_data0 = sa[t]; req_data1 = sb[t];
            end else begin
                req_valid = 1'b0; req_state = SW'($urandom); req_func = FW'($urandom);
                req_data0 = $urandom; req_data1 = $urandom;
            end
            @(posedge clk); #1;
            if (t >= LAT - 1) begin
                ov[t-LAT+1] = resp_valid; od[t-LAT+1] = resp_data; os[t-LAT+1] = resp_status;
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Specification-level model of one request: returns data/status and updates m_acc.
    function automatic void ref_op(input int f, input int s, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] d, output logic [2:0] st);
        longint dv, sum;
        logic [63:0] tmp;
        dv = 2 * longint'($countones(~(a ^ b))) - W;
        d = '0; st = 3'd0;
        case (f)
            F_DOT: begin tmp = dv; d = tmp[W-1:0]; end
            F_MAC: begin
                sum = longint'($signed(m_acc[s])) + dv;
`ifdef BNN_ACC_SATURATE_EN
                if (sum > (longint'(1) << (W-1)) - 1) begin sum = (longint'(1) << (W-1)) - 1; st = 3'd2; end
                else if (sum < -(longint'(1) << (W-1))) begin sum = -(longint'(1) << (W-1)); st = 3'd2; end
`endif
                tmp = sum; m_acc[s] = tmp[W-1:0]; d = m_acc[s];
            end
            F_READ:  d = m_acc[s];
            F_CLEAR: begin d = m_acc[s]; m_acc[s] = '0; end
            F_LOAD:  begin m_acc[s] = a; d = a; end
            default: st = 3'd1;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; clk_en = 1'b1; req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_vld got=%0b want=0", resp_valid); end
        checks++; if (resp_status !== 3'd0) begin failures++; $display("FAIL reset_status got=%0d want=0", resp_status); end
        checks++; if (resp_data !== '0) begin failures++; $display("FAIL reset_data got=%h want=0", resp_data); end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < NS; i++) set_slot(i, 1, i, F_READ, $urandom, $urandom);
        run_slots(NS);
        for (int i = 0; i < NS; i++) begin
            checks++;
            if (ov[i] !== 1'b1 || od[i] !== '0 || os[i] !== 3'd0)
                begin failures++; $display("FAIL reset_read s%0d got vld=%0b data=%h st=%0d want vld=1 data=0 st=0", i, ov[i], od[i], os[i]); end
        end
    endtask

    task automatic test_dot();
        set_slot(0, 0, 0, F_MAC, 32'hFFFFFFFF, 32'hFFFFFFFF);
        set_slot(1, 1, 0, F_DOT, 32'hFFFFFFFF, 32'hFFFFFFFF);
        set_slot(2, 1, 3, F_DOT, 32'h00000000, 32'hFFFFFFFF);
        set_slot(3, 0, 1, F_LOAD, 32'h0, 32'h0);
        run_slots(4);
        checks++; if (ov[0] !== 1'b0) begin failures++; $display("FAIL dot_early got vld=%0b want=0", ov[0]); end
        checks++; if (ov[1] !== 1'b1 || od[1] !== 32'd32 || os[1] !== 3'd0)
            begin failures++; $display("FAIL dot_plus got vld=%0b data=%h st=%0d want vld=1 data=00000020 st=0", ov[1], od[1], os[1]); end
        checks++; if (ov[2] !== 1'b1 || od[2] !== 32'hFFFFFFE0 || os[2] !== 3'd0)
            begin failures++; $display("FAIL dot_minus got vld=%0b data=%h st=%0d want vld=1 data=ffffffe0 st=0", ov[2], od[2], os[2]); end
        checks++; if (ov[3] !== 1'b0) begin failures++; $display("FAIL dot_late got vld=%0b want=0", ov[3]); end
    endtask

    task automatic test_mac();
        logic [W-1:0] ed [9];
        logic [2:0]   es [9];
        ed = '{32'd32, 32'd64, 32'd96, 32'd96, 32'd0, 32'd0, 32'd96, 32'd0, 32'd0};
        es = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd1, 3'd1};
        for (int i = 0; i < 3; i++) set_slot(i, 1, 1, F_MAC, 32'hFFFFFFFF, 32'hFFFFFFFF);
        set_slot(3, 1, 1, F_READ, $urandom, $urandom);
        set_slot(4, 1, 0, F_READ, $urandom, $urandom);
        set_slot(5, 1, 1, 6, 32'hFFFFFFFF, 32'hFFFFFFFF);
        set_slot(6, 1, 1, F_READ, $urandom, $urandom);
        set_slot(7, 1, 0, 5, 32'h0, 32'h0);
        set_slot(8, 1, 2, 7, 32'h0, 32'h0);
        run_slots(9);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (ov[i] !== 1'b1 || od[i] !== ed[i] || os[i] !== es[i])
                begin failures++; $display("FAIL mac_seq[%0d] got vld=%0b data=%h st=%0d want vld=1 data=%h st=%0d", i, ov[i], od[i], os[i], ed[i], es[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] exp_d;
        logic [2:0]   exp_s;
`ifdef BNN_ACC_SATURATE_EN
        exp_d = 32'h7FFFFFFF; exp_s = 3'd2;
`else
        exp_d = 32'h80000010; exp_s = 3'd0;
`endif
        set_slot(0, 1, 2, F_LOAD, 32'h7FFFFFF0, $urandom);
        set_slot(1, 1, 2, F_MAC, 32'h0, 32'h0);
        set_slot(2, 1, 2, F_READ, $urandom, $urandom);
        run_slots(3);
        checks++; if (ov[0] !== 1'b1 || od[0] !== 32'h7FFFFFF0 || os[0] !== 3'd0)
            begin failures++; $display("FAIL ovf_load got vld=%0b data=%h st=%0d want vld=1 data=7ffffff0 st=0", ov[0], od[0], os[0]); end
        checks++; if (ov[1] !== 1'b1 || od[1] !== exp_d || os[1] !== exp_s)
            begin failures++; $display("FAIL ovf_mac got vld=%0b data=%h st=%0d want vld=1 data=%h st=%0d", ov[1], od[1], os[1], exp_d, exp_s); end
        checks++; if (ov[2] !== 1'b1 || od[2] !== exp_d || os[2] !== 3'd0)
            begin failures++; $display("FAIL ovf_read got vld=%0b data=%h st=%0d want vld=1 data=%h st=0", ov[2], od[2], os[2], exp_d); end
    endtask

    task automatic test_clear();
        set_slot(0, 1, 1, F_CLEAR, $urandom, $urandom);
        set_slot(1, 1, 1, F_READ, $urandom, $urandom);
        run_slots(2);
        checks++; if (ov[0] !== 1'b1 || od[0] !== 32'd96) begin failures++; $display("FAIL clear_old got vld=%0b data=%h want vld=1 data=00000060", ov[0], od[0]); end
        checks++; if (ov[1] !== 1'b1 || od[1] !== 32'd0) begin failures++; $display("FAIL clear_read got vld=%0b data=%h want vld=1 data=0", ov[1], od[1]); end
    endtask

    task automatic test_stall();
        @(negedge clk);
        req_valid = 1'b1; req_state = 2'd3; req_func = FW'(F_LOAD); req_data0 = 32'h12345678; req_data1 = $urandom;
        @(posedge clk); #1;
        @(negedge clk);
        req_valid = 1'b1; req_state = 2'd3; req_func = FW'(F_MAC); req_data0 = 32'h0; req_data1 = 32'h0;
        @(posedge clk); #1;
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h12345678)
            begin failures++; $display("FAIL stall_first got vld=%0b data=%h want vld=1 data=12345678", resp_valid, resp_data); end
        // A request presented during the stall must be ignored.
        @(negedge clk);
        clk_en = 1'b0; req_valid = 1'b1; req_func = FW'(F_MAC); req_data0 = $urandom; req_data1 = $urandom;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== 32'h12345678 || resp_status !== 3'd0)
                begin failures++; $display("FAIL stall_hold[%0d] got vld=%0b data=%h st=%0d want vld=1 data=12345678 st=0", c, resp_valid, resp_data, resp_status); end
        end
        @(negedge clk);
        clk_en = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h12345698)
            begin failures++; $display("FAIL stall_second got vld=%0b data=%h want vld=1 data=12345698", resp_valid, resp_data); end
        @(posedge clk); #1;
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL stall_extra got vld=%0b want=0", resp_valid); end
        set_slot(0, 1, 3, F_READ, $urandom, $urandom);
        run_slots(1);
        checks++; if (ov[0] !== 1'b1 || od[0] !== 32'h12345698)
            begin failures++; $display("FAIL stall_state got vld=%0b data=%h want vld=1 data=12345698", ov[0], od[0]); end
    endtask

    task automatic test_reset_mid();
        int stale;
        stale = 0;
        @(negedge clk);
        req_valid = 1'b1; req_state = 2'd3; req_func = FW'(F_READ);
        @(posedge clk); #1;
        @(negedge clk);
        req_valid = 1'b1; req_state = 2'd1; req_func = FW'(F_MAC); req_data0 = 32'hFFFFFFFF; req_data1 = 32'hFFFFFFFF;
        @(posedge clk); #1;
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre got vld=%0b want=1", resp_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0 || resp_data !== '0 || resp_status !== 3'd0)
            begin failures++; $display("FAIL rstmid_drop got vld=%0b data=%h st=%0d want 0/0/0", resp_valid, resp_data, resp_status); end
        @(negedge clk); req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b0) stale++;
        end
        checks++; if (stale != 0) begin failures++; $display("FAIL rstmid_stale got=%0d want=0 stale responses", stale); end
        for (int i = 0; i < NS; i++) set_slot(i, 1, i, F_READ, $urandom, $urandom);
        run_slots(NS);
        for (int i = 0; i < NS; i++) begin
            checks++;
            if (ov[i] !== 1'b1 || od[i] !== '0)
                begin failures++; $display("FAIL rstmid_read s%0d got vld=%0b data=%h want vld=1 data=0", i, ov[i], od[i]); end
        end
    endtask

    task automatic test_random();
        logic          ev [MAXS];
        logic [W-1:0]  ed [MAXS];
        logic [2:0]    es [MAXS];
        logic [W-1:0]  a, b;
        int            n, f, st, sel;
        n = 250;
        for (int i = 0; i < NS; i++) m_acc[i] = '0;
        for (int i = 0; i < n; i++) begin
            f   = ($urandom_range(0, 9) < 4) ? F_MAC : int'($urandom_range(0, 7));
            st  = int'($urandom_range(0, NS - 1));
            a   = $urandom;
            sel = int'($urandom_range(0, 3));
            b   = (sel == 0) ? a : (sel == 1) ? ~a : $urandom;
            if (f == F_LOAD && $urandom_range(0, 1) == 1) a = ($urandom_range(0, 1) == 1) ? 32'h7FFFFFC0 : 32'h80000030;
            set_slot(i, ($urandom_range(0, 3) != 0), st, f, a, b);
            ev[i] = sv[i];
            ed[i] = '0; es[i] = 3'd0;
            if (sv[i]) ref_op(f, st, a, b, ed[i], es[i]);
        end
        run_slots(n);
        for (int i = 0; i < n; i++) begin
            checks++;
            if (ov[i] !== ev[i] || (ev[i] && (od[i] !== ed[i] || os[i] !== es[i])))
                begin failures++; $display("FAIL rand[%0d] f=%0d s=%0d got vld=%0b data=%h st=%0d want vld=%0b data=%h st=%0d",
                                           i, sf[i], sst[i], ov[i], od[i], os[i], ev[i], ed[i], es[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_dot();
        test_mac();
        test_overflow();
        test_clear();
        test_stall();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog sim time exceeded got=timeout want=finish");
        $fatal(1);
    end
endmodule

// File: doc/bnn_acc_l1_cfu.md
# bnn_acc_l1_cfu

- Pipelined CFU-L1 binary neural net dot-product unit with per-state signed accumulators.
- Computes the ±1-encoded XNOR/popcount dot product of two CFU_DATA_W-bit operands.
- Can fold each dot product into one of CFU_N_STATES accumulators, so a full neuron's sum is built without host-side adds.
- Fixed latency CFU_LAT; sits directly on a CFU-L1 request/response bus next to the other zoo CFUs.

## Interface
- CFU_LAT, 2: fixed response latency in cycles; legal range 1..8; elaboration error otherwise.
- CFU_DATA_W, 32: operand/result width; legal 32 or 64.
- CFU_N_STATES, 4: number of accumulator contexts; power of two, ≥1.
- CFU_FUNC_ID_W, 3: function-id width; ≥3.
- CFU_STATE_W, $clog2(CFU_N_STATES) (min 1): state-index width, derived.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clk_en  in  1  pipeline advance enable; low freezes every register, including the accumulators.
- req_valid  in  1  request present this cycle.
- req_state  in  CFU_STATE_W  accumulator index.
- req_func  in  CFU_FUNC_ID_W  function id.
- req_data0  in  CFU_DATA_W  operand a.
- req_data1  in  CFU_DATA_W  operand b.
- resp_valid  out  1  response valid.
- resp_status  out  3  0 = OK, 1 = error (undefined func).
- resp_data  out  CFU_DATA_W  result.

## Operation
- dot(a,b) = 2·popcount(~(a^b)) − CFU_DATA_W, signed.
  - Range −CFU_DATA_W..+CFU_DATA_W.
  - Sign-extended to CFU_DATA_W.
- Accumulators acc[0..CFU_N_STATES−1] are CFU_DATA_W-bit signed.
- Functions:
  - 0 DOT: resp_data = dot(a,b); no state change.
  - 1 MAC: acc[s] ← acc[s] + dot(a,b); resp_data = new acc[s].
  - 2 READ: resp_data = acc[s].
  - 3 CLEAR: acc[s] ← 0; resp_data = old acc[s].
  - 4 LOAD: acc[s] ← a; resp_data = a.
  - 5–7 and above: resp_status = 1, resp_data = 0, no state change.
- Pipeline: stages 1..CFU_LAT−1 hold the partial popcount (a tree split evenly across stages). The final stage (stage CFU_LAT) performs the accumulator read-modify-write and registers the response.
- Accumulator effects commit in the same clock edge that registers the response. A request issued k ≥ 1 cycles later to the same state always sees the committed value; no forwarding hazard exists.
- Requests may be issued every enabled cycle, with no back-pressure. req_valid low inserts a bubble, and a bubble never touches the accumulators.
- Overflow: MAC/LOAD arithmetic wraps modulo 2^CFU_DATA_W, unless saturation is configured.

## Timing
- Reset (rst_n low, async):
  - resp_valid = 0, resp_status = 0, resp_data = 0.
  - All pipeline valid bits = 0.
  - All acc = 0.
- Reset asserted mid-operation discards in-flight requests; no response is produced for them.
- First request is accepted on the first enabled clock edge after rst_n deasserts.
- Latency: a request sampled at enabled edge n produces its response at enabled edge n+CFU_LAT−1, i.e. resp_valid is high during the cycle after that edge, exactly CFU_LAT enabled cycles after issue.
- clk_en low stalls the whole pipeline. resp_valid/resp_data hold their values, and the same response remains presented until clk_en rises again.
- resp_valid is high for exactly one enabled cycle per valid request; responses are returned strictly in order.
- Operands are don't-care when req_valid = 0, and their values must not affect any state.

## Configuration
- BNN_ACC_SATURATE_EN defined: MAC clamps to [−2^(CFU_DATA_W−1), 2^(CFU_DATA_W−1)−1].
- BNN_ACC_SATURATE_EN defined: a MAC that clamps returns resp_status = 2 (OK-saturated). Data and state hold the clamped value.
- BNN_ACC_SATURATE_EN undefined: MAC wraps two's-complement, and resp_status is 0 for every defined function.

## Test plan
- DOT, a = b = 0xFFFFFFFF (W = 32) → resp_data = 32. a = 0x00000000, b = 0xFFFFFFFF → resp_data = 0xFFFFFFE0 (−32). Both arrive exactly CFU_LAT cycles after issue, back to back.
- MAC ×3 on state 1 with a = b = 0xFFFFFFFF, issued in consecutive cycles → responses 32, 64, 96. READ state 1 issued the next cycle → 96; READ state 0 → 0.
- LOAD state 2 with 0x7FFFFFF0, then MAC with a = b = 0 (dot = +32):
  - Wrap build: → 0x80000010, status 0.
  - Saturate build: → 0x7FFFFFFF, status 2.
- Undefined func 6 on state 1 after the MAC sequence → status 1, data 0. A following READ state 1 still returns 96.
- clk_en held low 3 cycles with 2 requests in flight → outputs frozen. Responses resume on clk_en rise with unchanged values and order.
- rst_n pulsed low mid-stream with a MAC in flight → resp_valid drops immediately, no stale response appears, and READ of every state returns 0.
